// File: rtl/jtag_tap_controller.sv
// IEEE 1149.1 TAP controller.
//
// Samples tms on rising tck and sequences the 16-state TAP FSM. Also provides
// decoded phase strobes, a TDO output enable, a TEST_LOGIC_RESET entry pulse,
// a TMS=1 run-length detector and a saturating Run-Test/Idle dwell counter.
//
// Ports:
//   tck            in   TAP clock, all state updates on posedge
//   trst           in   synchronous active-high reset
//   tms            in   test mode select
//   tap_state      out  current TAP state (registered)
//   capture_ir/shift_ir/update_ir, capture_dr/shift_dr/update_dr
//                  out  one-hot phase strobes decoded from tap_state
//   tdo_oe         out  shift_ir | shift_dr
//   tlr_entry      out  registered pulse on the first TEST_LOGIC_RESET cycle
//   tms_reset_seen out  TMS=1 run length >= TMS_RESET_LEN
//   rti_cnt        out  edges spent in RUN_TEST_IDLE since entry (saturating)
//   state_hist     out  last four distinct states, newest in slot 0
//                       (only when JTAG_TAP_STATE_TRACE_EN is defined)
//
// Optional feature macro: JTAG_TAP_STATE_TRACE_EN

package jtag_pkg;
  // Standard 1149.1 state encoding; all 16 codes are used.
  typedef enum logic [3:0] {
    Exit2Dr        = 4'h0,
    Exit1Dr        = 4'h1,
    ShiftDr        = 4'h2,
    PauseDr        = 4'h3,
    SelectIrScan   = 4'h4,
    UpdateDr       = 4'h5,
    CaptureDr      = 4'h6,
    SelectDrScan   = 4'h7,
    Exit2Ir        = 4'h8,
    Exit1Ir        = 4'h9,
    ShiftIr        = 4'hA,
    PauseIr        = 4'hB,
    RunTestIdle    = 4'hC,
    UpdateIr       = 4'hD,
    CaptureIr      = 4'hE,
    TestLogicReset = 4'hF
  } tap_ctrl_fsm_t;
endpackage

module jtag_tap_controller
  import jtag_pkg::*;
#(
  parameter int unsigned RTI_CNT_W     = 8,
  parameter int unsigned TMS_RESET_LEN = 5
) (
  input  logic                 tck,
  input  logic                 trst,
  input  logic                 tms,
  output tap_ctrl_fsm_t        tap_state,
  output logic                 capture_ir,
  output logic                 shift_ir,
  output logic                 update_ir,
  output logic                 capture_dr,
  output logic                 shift_dr,
  output logic                 update_dr,
  output logic                 tdo_oe,
  output logic                 tlr_entry,
  output logic                 tms_reset_seen,
`ifdef JTAG_TAP_STATE_TRACE_EN
  output tap_ctrl_fsm_t [3:0]  state_hist,
`endif
  output logic [RTI_CNT_W-1:0] rti_cnt
);

  localparam logic [RTI_CNT_W-1:0] RtiMax = '1;

  tap_ctrl_fsm_t          state_q, state_d;
  logic                   tlr_entry_q;
  logic [3:0]             tms_cnt_q;
  logic [RTI_CNT_W-1:0]   rti_cnt_q;

  always_comb begin
    state_d = TestLogicReset;
    unique case (state_q)
      TestLogicReset: state_d = tms ? TestLogicReset : RunTestIdle;
      RunTestIdle:    state_d = tms ? SelectDrScan   : RunTestIdle;
      SelectDrScan:   state_d = tms ? SelectIrScan   : CaptureDr;
      CaptureDr:      state_d = tms ? Exit1Dr        : ShiftDr;
      ShiftDr:        state_d = tms ? Exit1Dr        : ShiftDr;
      Exit1Dr:        state_d = tms ? UpdateDr       : PauseDr;
      PauseDr:        state_d = tms ? Exit2Dr        : PauseDr;
      Exit2Dr:        state_d = tms ? UpdateDr       : ShiftDr;
      UpdateDr:       state_d = tms ? SelectDrScan   : RunTestIdle;
      SelectIrScan:   state_d = tms ? TestLogicReset : CaptureIr;
      CaptureIr:      state_d = tms ? Exit1Ir        : ShiftIr;
      ShiftIr:        state_d = tms ? Exit1Ir        : ShiftIr;
      Exit1Ir:        state_d = tms ? UpdateIr       : PauseIr;
      PauseIr:        state_d = tms ? Exit2Ir        : PauseIr;
      Exit2Ir:        state_d = tms ? UpdateIr       : ShiftIr;
      UpdateIr:       state_d = tms ? SelectDrScan   : RunTestIdle;
      default:        state_d = TestLogicReset;
    endcase
  end

  always_ff @(posedge tck) begin
    if (trst) begin
      state_q     <= TestLogicReset;
      tlr_entry_q <= 1'b0;
      tms_cnt_q   <= '0;
      rti_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      tlr_entry_q <= (state_d == TestLogicReset) && (state_q != TestLogicReset);
      if (!tms) begin
        tms_cnt_q <= '0;
      end else if (tms_cnt_q != 4'hF) begin
        tms_cnt_q <= tms_cnt_q + 4'd1;
      end
      // Clear on entry, count while dwelling, hold once RTI is left.
      if (state_d == RunTestIdle) begin
        if (state_q != RunTestIdle) begin
          rti_cnt_q <= '0;
        end else if (rti_cnt_q != RtiMax) begin
          rti_cnt_q <= rti_cnt_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    tap_state      = state_q;
    capture_ir     = (state_q == CaptureIr);
    shift_ir       = (state_q == ShiftIr);
    update_ir      = (state_q == UpdateIr);
    capture_dr     = (state_q == CaptureDr);
    shift_dr       = (state_q == ShiftDr);
    update_dr      = (state_q == UpdateDr);
    tdo_oe         = shift_ir | shift_dr;
    tlr_entry      = tlr_entry_q;
    tms_reset_seen = ({28'd0, tms_cnt_q} >= 32'(TMS_RESET_LEN));
    rti_cnt        = rti_cnt_q;
  end

`ifdef JTAG_TAP_STATE_TRACE_EN
  tap_ctrl_fsm_t [3:0] hist_q;

  always_ff @(posedge tck) begin
    if (trst) begin
      hist_q <= {4{TestLogicReset}};
    end else if (state_d != state_q) begin
      hist_q <= {hist_q[2:0], state_d};
    end
  end

  assign state_hist = hist_q;

  a_strobe_onehot0: assert property (@(posedge tck)
    $onehot0({capture_ir, shift_ir, update_ir, capture_dr, shift_dr, update_dr}));
  a_tdo_oe_shift: assert property (@(posedge tck) tdo_oe |-> (shift_ir | shift_dr));
`endif

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Directed self-checking bench for jtag_tap_controller.
module tb_jtag_tap_controller;
  import jtag_pkg::*;

  logic          tck = 1'b0;
  logic          trst = 1'b1;
  logic          tms = 1'b0;
  tap_ctrl_fsm_t tap_state;
  logic          capture_ir, shift_ir, update_ir;
  logic          capture_dr, shift_dr, update_dr;
  logic          tdo_oe, tlr_entry, tms_reset_seen;
  logic [7:0]    rti_cnt;
`ifdef JTAG_TAP_STATE_TRACE_EN
  tap_ctrl_fsm_t [3:0] state_hist;
`endif

  int errors = 0;
  int checks = 0;
  // Strobe occupancy counters, accumulated by step and cleared per test.
  int n_cap_ir, n_sh_ir, n_upd_ir, n_cap_dr, n_sh_dr, n_upd_dr, n_oe, n_tlr;

  always #5 tck = ~tck;

  jtag_tap_controller #(
    .RTI_CNT_W     (8),
    .TMS_RESET_LEN (5)
  ) dut (
    .tck            (tck),
    .trst           (trst),
    .tms            (tms),
    .tap_state      (tap_state),
    .capture_ir     (capture_ir),
    .shift_ir       (shift_ir),
    .update_ir      (update_ir),
    .capture_dr     (capture_dr),
    .shift_dr       (shift_dr),
    .update_dr      (update_dr),
    .tdo_oe         (tdo_oe),
    .tlr_entry      (tlr_entry),
    .tms_reset_seen (tms_reset_seen),
`ifdef JTAG_TAP_STATE_TRACE_EN
    .state_hist     (state_hist),
`endif
    .rti_cnt        (rti_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_counts();
    n_cap_ir = 0; n_sh_ir = 0; n_upd_ir = 0;
    n_cap_dr = 0; n_sh_dr = 0; n_upd_dr = 0;
    n_oe = 0; n_tlr = 0;
  endtask

  // Drive tms on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic t);
    @(negedge tck);
    tms = t;
    @(posedge tck);
    #1;
    n_cap_ir += int'(capture_ir); n_sh_ir  += int'(shift_ir);
    n_upd_ir += int'(update_ir);  n_cap_dr += int'(capture_dr);
    n_sh_dr  += int'(shift_dr);   n_upd_dr += int'(update_dr);
    n_oe     += int'(tdo_oe);     n_tlr    += int'(tlr_entry);
  endtask

  initial begin
    bit            t2[10];
    tap_ctrl_fsm_t e2[10];
    bit            t3[13];
    tap_ctrl_fsm_t e3[13];
    tap_ctrl_fsm_t e4[5];
    int            exp_rti;

    t2 = '{1, 1, 0, 0, 0, 0, 0, 1, 1, 0};
    e2 = '{SelectDrScan, SelectIrScan, CaptureIr, ShiftIr, ShiftIr, ShiftIr, ShiftIr,
           Exit1Ir, UpdateIr, RunTestIdle};
    t3 = '{1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 1, 0};
    e3 = '{SelectDrScan, CaptureDr, ShiftDr, ShiftDr, Exit1Dr, PauseDr, PauseDr, Exit2Dr,
           ShiftDr, ShiftDr, Exit1Dr, UpdateDr, RunTestIdle};
    e4 = '{Exit1Dr, UpdateDr, SelectDrScan, SelectIrScan, TestLogicReset};

    // 1: reset two cycles, then release.
    clr_counts();
    trst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'b0);
      check_eq("rst_state", 32'(tap_state), 32'(TestLogicReset));
      check_eq("rst_tlr_entry", 32'(tlr_entry), 32'd0);
      check_eq("rst_rti", 32'(rti_cnt), 32'd0);
      check_eq("rst_strobes", {26'd0, capture_ir, shift_ir, update_ir, capture_dr,
                               shift_dr, update_dr}, 32'd0);
      check_eq("rst_oe", 32'(tdo_oe), 32'd0);
    end
    trst = 1'b0;
    step(1'b0);
    check_eq("rel_state", 32'(tap_state), 32'(RunTestIdle));
    check_eq("rel_tlr_entry_cnt", n_tlr, 0);
    check_eq("rel_tms_seen", 32'(tms_reset_seen), 32'd0);

    // 2: IR scan with 4 shift cycles.
    clr_counts();
    for (int i = 0; i < 10; i++) begin
      step(t2[i]);
      check_eq($sformatf("ir_state%0d", i), 32'(tap_state), 32'(e2[i]));
    end
    check_eq("ir_shift_cnt", n_sh_ir, 4);
    check_eq("ir_oe_cnt", n_oe, 4);
    check_eq("ir_update_cnt", n_upd_ir, 1);
    check_eq("ir_capture_cnt", n_cap_ir, 1);
    check_eq("ir_dr_strobes", n_cap_dr + n_sh_dr + n_upd_dr, 0);

    // 3: DR scan with pause.
    clr_counts();
    for (int i = 0; i < 13; i++) begin
      step(t3[i]);
      check_eq($sformatf("dr_state%0d", i), 32'(tap_state), 32'(e3[i]));
    end
    check_eq("dr_update_cnt", n_upd_dr, 1);
    check_eq("dr_capture_cnt", n_cap_dr, 1);
    check_eq("dr_shift_cnt", n_sh_dr, 4);
    check_eq("dr_oe_cnt", n_oe, 4);

    // 4: five TMS=1 edges from SHIFT_DR land in TEST_LOGIC_RESET.
    step(1'b1); step(1'b0); step(1'b0);
    check_eq("t4_in_shift", 32'(tap_state), 32'(ShiftDr));
    clr_counts();
    for (int i = 0; i < 5; i++) begin
      step(1'b1);
      check_eq($sformatf("t4_state%0d", i), 32'(tap_state), 32'(e4[i]));
      check_eq($sformatf("t4_tms_seen%0d", i), 32'(tms_reset_seen), (i == 4) ? 32'd1 : 32'd0);
    end
    check_eq("t4_tlr_entry", 32'(tlr_entry), 32'd1);
    check_eq("t4_update_cnt", n_upd_dr, 1);
    step(1'b1);
    check_eq("t4_tlr_hold", 32'(tap_state), 32'(TestLogicReset));
    check_eq("t4_tlr_entry_once", 32'(tlr_entry), 32'd0);
    check_eq("t4_tms_seen_hold", 32'(tms_reset_seen), 32'd1);

    // 5: RTI dwell counter saturation, hold and re-entry.
    step(1'b0);
    check_eq("t5_enter", 32'(tap_state), 32'(RunTestIdle));
    check_eq("t5_rti0", 32'(rti_cnt), 32'd0);
    check_eq("t5_tms_seen_clr", 32'(tms_reset_seen), 32'd0);
    for (int i = 1; i <= 300; i++) begin
      step(1'b0);
      exp_rti = (i > 255) ? 255 : i;
      check_eq($sformatf("t5_rti%0d", i), 32'(rti_cnt), exp_rti);
    end
    step(1'b1);
    check_eq("t5_leave", 32'(tap_state), 32'(SelectDrScan));
    check_eq("t5_hold_a", 32'(rti_cnt), 32'd255);
    step(1'b0);
    check_eq("t5_hold_b", 32'(rti_cnt), 32'd255);
    step(1'b1); step(1'b1); step(1'b0);
    check_eq("t5_reenter", 32'(tap_state), 32'(RunTestIdle));
    check_eq("t5_rti_clr", 32'(rti_cnt), 32'd0);
    step(1'b0);
    check_eq("t5_rti_1", 32'(rti_cnt), 32'd1);

    // 6: reset mid SHIFT_IR.
    step(1'b1); step(1'b1); step(1'b0); step(1'b0); step(1'b0);
    check_eq("t6_in_shift", 32'(tap_state), 32'(ShiftIr));
    check_eq("t6_rti_held", 32'(rti_cnt), 32'd1);
    clr_counts();
    trst = 1'b1;
    step(1'b0);
    check_eq("t6_state", 32'(tap_state), 32'(TestLogicReset));
    check_eq("t6_rti", 32'(rti_cnt), 32'd0);
    check_eq("t6_tlr_entry", 32'(tlr_entry), 32'd0);
    step(1'b0);
    check_eq("t6_rst_beats_tms0", 32'(tap_state), 32'(TestLogicReset));
    trst = 1'b0;
    step(1'b0);
    check_eq("t6_release", 32'(tap_state), 32'(RunTestIdle));
    check_eq("t6_no_update", n_upd_ir, 0);
    check_eq("t6_no_tlr_pulse", n_tlr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jtag_tap_controller.md
Name: jtag_tap_controller

Overview:
- IEEE 1149.1 TAP controller state machine. Samples TMS on rising TCK and drives `tap_state` (type `tap_ctrl_fsm_t`, from `jtag_pkg`).
- `tap_state` sequences the instruction register and all data registers: capture, shift and update of IR/DR.
- Also provides decoded one-hot phase strobes, a TDO output-enable and a Run-Test/Idle dwell counter. The AXI bridge uses the counter to pace transactions.

Parameters:
- RTI_CNT_W, 8, width of the Run-Test/Idle dwell counter; saturating.
- TMS_RESET_LEN, 5, consecutive TMS=1 rising edges that raise `tms_reset_seen`; legal range 5..15.

Ports:
- tck  input  1  TAP clock; the only clock; all state updates on posedge.
- trst  input  1  synchronous, active-high reset; sampled on posedge tck.
- tms  input  1  test mode select.
- tap_state  output  $bits(tap_ctrl_fsm_t)  current TAP state, registered.
- capture_ir, shift_ir, update_ir  output  1 each  high while in CAPTURE_IR / SHIFT_IR / UPDATE_IR.
- capture_dr, shift_dr, update_dr  output  1 each  high while in CAPTURE_DR / SHIFT_DR / UPDATE_DR.
- tdo_oe  output  1  shift_ir | shift_dr.
- tlr_entry  output  1  one-cycle pulse on the first cycle in TEST_LOGIC_RESET after arriving from any other state.
- tms_reset_seen  output  1  high while the TMS=1 run-length counter is ≥ TMS_RESET_LEN.
- rti_cnt  output  RTI_CNT_W  rising edges spent in RUN_TEST_IDLE since entry.

Behaviour:
- Reset (trst=1 at posedge tck):
  - tap_state=TEST_LOGIC_RESET, rti_cnt=0, TMS run counter=0, tlr_entry=0.
  - Reset wins over tms in the same cycle.
  - Asserting reset mid-SHIFT forces TEST_LOGIC_RESET on the next edge; no UPDATE state is visited.
- Next-state function, evaluated each posedge; notation is tms=0 → / tms=1 →:
  - TEST_LOGIC_RESET: RUN_TEST_IDLE / TEST_LOGIC_RESET.
  - RUN_TEST_IDLE: RUN_TEST_IDLE / SELECT_DR_SCAN.
  - SELECT_DR_SCAN: CAPTURE_DR / SELECT_IR_SCAN.
  - CAPTURE_DR: SHIFT_DR / EXIT1_DR.
  - SHIFT_DR: SHIFT_DR / EXIT1_DR.
  - EXIT1_DR: PAUSE_DR / UPDATE_DR.
  - PAUSE_DR: PAUSE_DR / EXIT2_DR.
  - EXIT2_DR: SHIFT_DR / UPDATE_DR.
  - UPDATE_DR: RUN_TEST_IDLE / SELECT_DR_SCAN.
  - SELECT_IR_SCAN: CAPTURE_IR / TEST_LOGIC_RESET.
  - IR branch mirrors the DR branch (CAPTURE_IR … UPDATE_IR).
  - UPDATE_IR: RUN_TEST_IDLE / SELECT_DR_SCAN.
- Unreachable encodings: next state is TEST_LOGIC_RESET.
- Phase strobes and tdo_oe:
  - Combinational decode of registered tap_state; zero latency relative to the state.
  - All are 0 out of reset.
  - Consumers sample shift data on posedge and apply update data on negedge.
- tlr_entry:
  - Registered.
  - 1 in the cycle where tap_state==TEST_LOGIC_RESET and the previous state was not TEST_LOGIC_RESET.
  - Never 1 on the cycle following trst.
- TMS run counter:
  - 4 bits; increments on tms=1, saturates at 15; clears on tms=0.
  - From any state, TMS_RESET_LEN ones must land in TEST_LOGIC_RESET; the FSM guarantees this for TMS_RESET_LEN ≥ 5.
- rti_cnt:
  - Clears to 0 on the edge entering RUN_TEST_IDLE.
  - Increments by 1 on each further edge that stays in RUN_TEST_IDLE; saturates at 2^RTI_CNT_W−1.
  - Holds its value after leaving RUN_TEST_IDLE.
- Simultaneous events: none. tms is the only input besides trst, and trst dominates.

Optional Feature:
- Macro: JTAG_TAP_STATE_TRACE_EN.
- When defined:
  - Adds output `state_hist` (4 × $bits(tap_ctrl_fsm_t)), a shift history of the last four distinct states, newest in the LSB slot.
  - Pushes only on edges where next state ≠ current state.
  - Resets to all TEST_LOGIC_RESET.
  - Adds simulation assertions: exactly one phase strobe high at most, and tdo_oe implies shift_ir|shift_dr.
- When undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
1. trst=1 for 2 cycles with tms=0, then release, tms=0 → tap_state TEST_LOGIC_RESET during reset, RUN_TEST_IDLE one edge after release; tlr_entry stays 0.
2. From RUN_TEST_IDLE, tms sequence 1,1,0,0,0,0,0,1,1,0 (IR scan, 4 shift bits) → states SELECT_DR_SCAN, SELECT_IR_SCAN, CAPTURE_IR, SHIFT_IR×4 (shift_ir=tdo_oe=1 exactly 4 cycles), EXIT1_IR, UPDATE_IR (update_ir=1 one cycle), RUN_TEST_IDLE.
3. DR scan with pause: 1,0,0,0,1,0,0,1,0,0,1,1,0 → SHIFT_DR, EXIT1_DR, PAUSE_DR×2, EXIT2_DR, SHIFT_DR, EXIT1_DR, UPDATE_DR, RUN_TEST_IDLE; update_dr pulses once.
4. From SHIFT_DR, hold tms=1 for 5 edges → TEST_LOGIC_RESET on the 5th edge; tlr_entry=1 one cycle; tms_reset_seen=1 after the 5th edge; update_dr seen once en route.
5. Enter RUN_TEST_IDLE with RTI_CNT_W=8 and hold tms=0 for 300 edges → rti_cnt counts 0..255 and sticks at 255. Then tms=1 → rti_cnt holds 255. Re-entering RUN_TEST_IDLE → rti_cnt=0.
6. Assert trst mid-SHIFT_IR with tms=0 → next edge TEST_LOGIC_RESET, update_ir never asserted, rti_cnt=0.
